// File: rtl/pixel_fifo_writer.sv
// ---------------------------------------------------------------------------
// pixel_fifo_writer
//
// Write-side streamer for the dual-clock pixel FIFO feeding the VGA reader.
// Accepts pixels from the frame composer over valid/ready and writes them
// into the FIFO through a registered wrreq/data pair backed by one skid
// register, so wrfull back-pressure never loses or duplicates a pixel.
// Tracks the raster position of the next pixel to be committed and pulses
// frame_done once the whole frame has been written.
//
// Ports
//   clk          system clock (single clock domain)
//   rst_n        synchronous active-low reset
//   frame_start  request to stream one frame, sampled only in IDLE
//   s_pixel      source pixel {R[23:16], G[15:8], B[7:0]}
//   s_valid      s_pixel is valid
//   s_ready      block accepts s_pixel this cycle (registered)
//   fifo_data    FIFO write data (registered)
//   fifo_wrreq   FIFO write request (registered)
//   fifo_wrfull  FIFO full, write-clock domain
//   x, y         column / row of the next pixel to be committed
//   busy         high whenever the FSM is not in IDLE
//   frame_done   one-cycle pulse after the final commit of a frame
// ---------------------------------------------------------------------------
module pixel_fifo_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PIXEL_W  = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [PIXEL_W-1:0] s_pixel,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [PIXEL_W-1:0] fifo_data,
    output logic               fifo_wrreq,
    input  logic               fifo_wrfull,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               busy,
    output logic               frame_done
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int ACC_W     = $clog2(FRAME_PIX + 1);

    localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(FRAME_PIX);
    localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam logic [9:0]       X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic               skid_valid_r;
    logic [PIXEL_W-1:0] skid_data_r;
    logic [ACC_W-1:0]   acc_cnt_r;

    logic               accept_s;
    logic               commit_s;
    state_t             state_nxt_s;
    logic               out_valid_nxt_s;
    logic [PIXEL_W-1:0] out_data_nxt_s;
    logic               skid_valid_nxt_s;
    logic [PIXEL_W-1:0] skid_data_nxt_s;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [9:0]         x_nxt_s;
    logic [9:0]         y_nxt_s;
    logic               s_ready_nxt_s;

    // Next-state logic: buffer steering, counters, FSM transitions, ready.
    always_comb begin
        accept_s         = s_valid & s_ready;
        commit_s         = fifo_wrreq & ~fifo_wrfull;

        out_valid_nxt_s  = fifo_wrreq;
        out_data_nxt_s   = fifo_data;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        acc_nxt_s        = acc_cnt_r;
        x_nxt_s          = x;
        y_nxt_s          = y;
        state_nxt_s      = state_r;

        // Output register free this cycle: skid pixel has priority to keep
        // order. Ready is only high with an empty skid, so an accept and a
        // full skid never coincide.
        if (!fifo_wrreq || commit_s) begin
            if (skid_valid_r) begin
                out_valid_nxt_s  = 1'b1;
                out_data_nxt_s   = skid_data_r;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                out_valid_nxt_s  = 1'b1;
                out_data_nxt_s   = s_pixel;
            end else begin
                out_valid_nxt_s  = 1'b0;
            end
        end else begin
            // Output register stalled: park the accepted pixel in the skid.
            if (accept_s) begin
                skid_valid_nxt_s = 1'b1;
                skid_data_nxt_s  = s_pixel;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end

        if (accept_s) begin
            acc_nxt_s = acc_cnt_r + ACC_ONE;
        end else begin
            acc_nxt_s = acc_cnt_r;
        end

        // Raster position advances per commit; y wraps after the final pixel.
        if (commit_s) begin
            if (x == X_LAST) begin
                x_nxt_s = 10'd0;
                if (y == Y_LAST) begin
                    y_nxt_s = 10'd0;
                end else begin
                    y_nxt_s = y + 10'd1;
                end
            end else begin
                x_nxt_s = x + 10'd1;
            end
        end else begin
            x_nxt_s = x;
        end

        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_nxt_s = STREAM;
                    acc_nxt_s   = '0;
                    x_nxt_s     = 10'd0;
                    y_nxt_s     = 10'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (acc_nxt_s == ACC_FULL) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            FLUSH: begin
                if (!out_valid_nxt_s && !skid_valid_nxt_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Ready is precomputed for the next cycle so it can be registered;
        // looking at the next acc count prevents accepting past the frame.
        s_ready_nxt_s = (state_nxt_s == STREAM) && !skid_valid_nxt_s &&
                        (acc_nxt_s < ACC_FULL);
    end

    // State, buffers, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            acc_cnt_r    <= '0;
            fifo_wrreq   <= 1'b0;
            fifo_data    <= '0;
            x            <= 10'd0;
            y            <= 10'd0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            acc_cnt_r    <= acc_nxt_s;
            fifo_wrreq   <= out_valid_nxt_s;
            fifo_data    <= out_data_nxt_s;
            x            <= x_nxt_s;
            y            <= y_nxt_s;
            s_ready      <= s_ready_nxt_s;
            busy         <= (state_nxt_s != IDLE);
            frame_done   <= (state_nxt_s == DONE);
        end
    end

endmodule
